// File: rtl/xpb_pkg.sv
// Shared definitions for the XPB lookup sequencer: default widths, the
// sequencer state encoding and a digit extraction helper.
package xpb_pkg;

    localparam int DIGIT_W_DEF = 5;
    localparam int WORD_W_DEF  = 1024;

    // Widest packed digit vector digit_sel accepts (NUM_SEGMENTS*DIGIT_W).
    localparam int VEC_MAX     = 256;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } state_t;

    // Returns digit idx (each dw bits wide) of vec, zero-extended to an int.
    function automatic int digit_sel(input logic [VEC_MAX-1:0] vec,
                                     input int idx,
                                     input int dw);
        logic [31:0] low;
        logic [31:0] mask;
        low  = 32'(vec >> (idx * dw));
        mask = (32'd1 << dw) - 32'd1;
        return int'(low & mask);
    endfunction

endpackage

// File: rtl/xpb_accum_seq.sv
// Time-multiplexed XPB lookup sequencer. Captures NUM_SEGMENTS digits on
// start, issues one table lookup per cycle to an external segment-muxed
// table bank (1-cycle registered read), and sums the returned constants.
// Schedule: start at cycle 0, lookups at cycles 1..N, done at cycle N+2.
// Optional build macro XPB_ZERO_SKIP_EN: suppress lut_en for zero digits
// (table entry for digit 0 is 0, so the sum and the schedule are unchanged).
//
// Handshake: the table bank must present lut_data exactly one cycle after
// a cycle with lut_en=1; lut_seg/lut_digit are only meaningful while
// lut_en=1. start is a level sampled only in IDLE; there is no back-pressure.
module xpb_accum_seq
    import xpb_pkg::*;
#(
    parameter int NUM_SEGMENTS = 8,
    parameter int DIGIT_W      = DIGIT_W_DEF,
    parameter int WORD_W       = WORD_W_DEF,
    parameter int SEG_W        = $clog2(NUM_SEGMENTS),
    parameter int ACC_W        = WORD_W + SEG_W
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [NUM_SEGMENTS*DIGIT_W-1:0] digits_in,
    output logic                            busy,
    output logic                            done,
    output logic                            lut_en,
    output logic [SEG_W-1:0]                lut_seg,
    output logic [DIGIT_W-1:0]              lut_digit,
    input  logic [WORD_W-1:0]               lut_data,
    output logic [ACC_W-1:0]                acc_out,
    output state_t                          state_dbg
);

    localparam int VEC_W = NUM_SEGMENTS * DIGIT_W;
    localparam logic [SEG_W-1:0] LAST_SEG = SEG_W'(NUM_SEGMENTS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [SEG_W-1:0]    seg_cnt;
    logic [VEC_W-1:0]    digits_q;
    logic [ACC_W-1:0]    acc;
    logic                vld_d;
    logic [VEC_MAX-1:0]  vec_ext;
    logic [DIGIT_W-1:0]  cur_digit;
    logic                issue;
    logic                accept;

    assign accept = (state == IDLE) && start;
    assign issue  = (state == ISSUE);

    // Select the digit addressed by the segment counter.
    always_comb begin
        vec_ext              = '0;
        vec_ext[VEC_W-1:0]   = digits_q;
        cur_digit            = DIGIT_W'(digit_sel(vec_ext, int'(seg_cnt), DIGIT_W));
    end

`ifdef XPB_ZERO_SKIP_EN
    // Zero digits read a zero table entry, so the read is skipped.
    assign lut_en = issue && (cur_digit != '0);
`else
    assign lut_en = issue;
`endif

    // seg_cnt parks on the last segment, so these hold after the sequence.
    assign lut_seg   = seg_cnt;
    assign lut_digit = cur_digit;
    assign busy      = (state == ISSUE) || (state == DRAIN);
    assign done      = (state == DONE);
    assign acc_out   = acc;
    assign state_dbg = state;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; the schedule is fixed and data-independent.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ISSUE;
            ISSUE:   if (seg_cnt == LAST_SEG) state_nxt = DRAIN;
            DRAIN:   state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Digit capture, segment counter and accumulate pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            digits_q <= '0;
            seg_cnt  <= '0;
            acc      <= '0;
            vld_d    <= 1'b0;
        end else begin
            vld_d <= lut_en;
            if (accept) begin
                digits_q <= digits_in;
                seg_cnt  <= '0;
                acc      <= '0;
            end else begin
                if (issue && (seg_cnt != LAST_SEG)) begin
                    seg_cnt <= seg_cnt + SEG_W'(1);
                end
                if (vld_d) begin
                    acc <= acc + ACC_W'(lut_data);
                end
            end
        end
    end

endmodule

// File: tb/tb_xpb_accum_seq.sv
// Self-checking bench for xpb_accum_seq with NUM_SEGMENTS=4, WORD_W=16.
// A registered model table returns (seg+1)*64+digit (or 16'hFFFF in
// saturate mode), and 0 for digit 0. Optional macro: XPB_ZERO_SKIP_EN.
module tb_xpb_accum_seq;
    import xpb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 5;
    localparam int WW = 16;
    localparam int SW = 2;
    localparam int AW = 18;

`ifdef XPB_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [N*DW-1:0] digits_in;
    logic            busy;
    logic            done;
    logic            lut_en;
    logic [SW-1:0]   lut_seg;
    logic [DW-1:0]   lut_digit;
    logic [WW-1:0]   lut_data = '0;
    logic [AW-1:0]   acc_out;
    state_t          state_dbg;

    logic [AW-1:0]   exp_q[$];
    int              n_checks = 0;
    int              n_fails  = 0;
    bit              ffff_mode = 1'b0;

    xpb_accum_seq #(
        .NUM_SEGMENTS (N),
        .DIGIT_W      (DW),
        .WORD_W       (WW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .digits_in (digits_in),
        .busy      (busy),
        .done      (done),
        .lut_en    (lut_en),
        .lut_seg   (lut_seg),
        .lut_digit (lut_digit),
        .lut_data  (lut_data),
        .acc_out   (acc_out),
        .state_dbg (state_dbg)
    );

    // Clock.
    always #5 clk = ~clk;

    function automatic logic [WW-1:0] table_val(input int s, input int d, input bit ff);
        if (d == 0) return '0;
        if (ff) return 16'hFFFF;
        return WW'((s + 1) * 64 + d);
    endfunction

    // Registered model of the table bank: one cycle read latency.
    always @(posedge clk) begin
        if (lut_en === 1'b1) lut_data <= table_val(int'(lut_seg), int'(lut_digit), ffff_mode);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full sequence; start driven in cycle 0, checks on cycles 1..7.
    // ga/gb: cycles in which start is re-asserted (0 = none).
    task automatic run(input logic [N*DW-1:0] digs, input bit ff,
                       input int ga, input int gb, input string name);
        logic [AW-1:0] sum;
        bit            en_exp[N];
        logic [DW-1:0] d;
        logic [AW-1:0] got;
        logic [AW-1:0] want;
        sum = '0;
        for (int s = 0; s < N; s++) begin
            d = digs[s*DW +: DW];
            en_exp[s] = !(SKIP && (d == '0));
            sum += AW'(table_val(s, int'(d), ff));
        end
        ffff_mode = ff;
        digits_in = digs;
        start     = 1'b1;
        exp_q.push_back(sum);
        step();
        start     = 1'b0;
        digits_in = (N*DW)'($urandom_range(0, (1 << (N*DW)) - 1));
        for (int cyc = 1; cyc <= 6; cyc++) begin
            check($sformatf("%s.c%0d.busy", name, cyc), 32'(busy), 32'(cyc <= 5));
            check($sformatf("%s.c%0d.done", name, cyc), 32'(done), 32'(cyc == 6));
            check($sformatf("%s.c%0d.lut_en", name, cyc), 32'(lut_en),
                  32'((cyc <= 4) && en_exp[(cyc <= 4) ? cyc - 1 : 0]));
            if (cyc <= 4 && lut_en === 1'b1) begin
                check($sformatf("%s.c%0d.lut_seg", name, cyc), 32'(lut_seg), 32'(cyc - 1));
                check($sformatf("%s.c%0d.lut_digit", name, cyc), 32'(lut_digit),
                      32'(digs[(cyc-1)*DW +: DW]));
            end
            if (done === 1'b1) begin
                if (exp_q.size() > 0) begin
                    got = acc_out;
                    want = exp_q.pop_front();
                    check($sformatf("%s.acc_out", name), 32'(got), 32'(want));
                end
            end
            if (cyc < 6) begin
                start = (cyc == ga) || (cyc == gb);
                step();
                start = 1'b0;
            end
        end
        check($sformatf("%s.queue_empty", name), 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        start = (ga == 6) || (gb == 6);
        step();
        start = 1'b0;
        check($sformatf("%s.c7.done", name), 32'(done), 32'd0);
        check($sformatf("%s.c7.busy", name), 32'(busy), 32'd0);
        check($sformatf("%s.c7.acc_hold", name), 32'(acc_out), 32'(sum));
    endtask

    localparam logic [N*DW-1:0] DIGS_1234 = {5'd4, 5'd3, 5'd2, 5'd1};

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        digits_in = '0;
        step();
        step();
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.lut_en", 32'(lut_en), 32'd0);
        check("rst.lut_seg", 32'(lut_seg), 32'd0);
        check("rst.lut_digit", 32'(lut_digit), 32'd0);
        check("rst.acc_out", 32'(acc_out), 32'd0);
        reset = 1'b0;
        step();

        // All-zero digits.
        run('0, 1'b0, 0, 0, "s1");
        // Distinct digits: 65+130+195+260 = 650.
        run(DIGS_1234, 1'b0, 0, 0, "s2");
        // Start glitches while busy and in DONE, then back-to-back restart.
        run(DIGS_1234, 1'b0, 2, 5, "s3a");
        run(DIGS_1234, 1'b0, 6, 0, "s3b");
        run(DIGS_1234, 1'b0, 0, 0, "s3c");
        // Maximum constants: 4*65535 = 262140 needs all 18 bits.
        run({4{5'd31}}, 1'b1, 0, 0, "s4");

        // Reset in cycle 3 of a run.
        ffff_mode = 1'b0;
        digits_in = DIGS_1234;
        start     = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        check("s5.c3.busy", 32'(busy), 32'd1);
        check("s5.c3.acc_partial", 32'(acc_out), 32'd65);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("s5.c4.busy", 32'(busy), 32'd0);
        check("s5.c4.acc_out", 32'(acc_out), 32'd0);
        check("s5.c4.lut_en", 32'(lut_en), 32'd0);
        check("s5.c4.done", 32'(done), 32'd0);
        for (int k = 5; k <= 8; k++) begin
            step();
            check($sformatf("s5.c%0d.done", k), 32'(done), 32'd0);
            check($sformatf("s5.c%0d.acc_out", k), 32'(acc_out), 32'd0);
        end
        run(DIGS_1234, 1'b0, 0, 0, "s5b");

        // Mixed zero digits: 133 + 263 = 396.
        run({5'd7, 5'd0, 5'd5, 5'd0}, 1'b0, 0, 0, "s6");

        // Random digit vectors.
        for (int r = 0; r < 4; r++) begin
            logic [N*DW-1:0] rd;
            for (int s = 0; s < N; s++) rd[s*DW +: DW] = DW'($urandom_range(0, 31));
            run(rd, 1'b0, int'($urandom_range(0, 6)), 0, $sformatf("rnd%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
